// File: rtl/line_buff_fill.sv
// Fill engine for the VGA double line buffer: streams one tile line from frame
// memory into buffer A or B on request and pulses the matching fill-done bit.
module line_buff_fill #(
    parameter int TILE_PER_LINE  = 160,
    parameter int TILE_LINES     = 120,
    parameter int DEPTH_COLR     = 12,
    parameter int MEM_RD_LAT     = 1,
    parameter int MEM_ADDR_WIDTH = $clog2(TILE_PER_LINE * TILE_LINES),
    parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                buff_fill_req_i,
    input  logic                      frame_start_i,
    input  logic [DEPTH_COLR-1:0]     mem_data_i,
    output logic                      mem_ren_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [1:0]                buff_wen_o,
    output logic [TILE_CTR_WIDTH-1:0] buff_addr_o,
    output logic [DEPTH_COLR-1:0]     buff_data_o,
    output logic [1:0]                buff_fill_done_o,
    output logic                      busy_o
);

    localparam int LINE_IDX_WIDTH = (TILE_LINES > 1) ? $clog2(TILE_LINES) : 1;
    localparam logic [TILE_CTR_WIDTH-1:0] COL_LAST  = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
    localparam logic [TILE_CTR_WIDTH-1:0] COL_ONE   = TILE_CTR_WIDTH'(1);
    localparam logic [LINE_IDX_WIDTH-1:0] LINE_LAST = LINE_IDX_WIDTH'(TILE_LINES - 1);
    localparam logic [LINE_IDX_WIDTH-1:0] LINE_ONE  = LINE_IDX_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] BASE_STEP = MEM_ADDR_WIDTH'(TILE_PER_LINE);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = MEM_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e                      state_q, state_d;
    logic                        sel_q, sel_d;
    logic [TILE_CTR_WIDTH-1:0]   col_q, col_d;
    logic [LINE_IDX_WIDTH-1:0]   line_idx_q, line_idx_d;
    logic [MEM_ADDR_WIDTH-1:0]   line_base_q, line_base_d;
    logic                        fs_pend_q, fs_pend_d;
    logic                        mem_ren_q, mem_ren_d;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]                  buff_wen_q, buff_wen_d;
    logic [TILE_CTR_WIDTH-1:0]   buff_addr_q, buff_addr_d;
    logic [DEPTH_COLR-1:0]       buff_data_q, buff_data_d;
    logic [1:0]                  done_q, done_d;
    logic                        busy_q, busy_d;
    logic [MEM_RD_LAT:0]         vld_pipe_q;
    logic [TILE_CTR_WIDTH-1:0]   col_pipe_q [MEM_RD_LAT+1];

    logic       start;
    logic       pipe_busy;
    logic [1:0] sel_hot;

    assign start     = (state_q == IDLE) && (buff_fill_req_i != 2'b00);
    assign pipe_busy = |vld_pipe_q;
    assign sel_hot   = sel_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (col_q == COL_LAST) state_d = DRAIN;
            DRAIN:   if (!pipe_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A frame start seen while busy is parked in fs_pend and replaces the line advance at DONE.
    always_comb begin
        sel_d       = sel_q;
        col_d       = col_q;
        mem_ren_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        line_idx_d  = line_idx_q;
        line_base_d = line_base_q;
        fs_pend_d   = fs_pend_q;
        case (state_q)
            IDLE: begin
                fs_pend_d = 1'b0;
                if (frame_start_i) begin
                    line_idx_d  = '0;
                    line_base_d = '0;
                end
                if (start) begin
                    sel_d      = ~buff_fill_req_i[0];
                    col_d      = '0;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = frame_start_i ? '0 : line_base_q;
                end
            end
            READ: begin
                fs_pend_d = fs_pend_q | frame_start_i;
                if (col_q != COL_LAST) begin
                    col_d      = col_q + COL_ONE;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                end
            end
            DRAIN: begin
                fs_pend_d = fs_pend_q | frame_start_i;
            end
            DONE: begin
                fs_pend_d = 1'b0;
                if (fs_pend_q || frame_start_i || (line_idx_q == LINE_LAST)) begin
                    line_idx_d  = '0;
                    line_base_d = '0;
                end else begin
                    line_idx_d  = line_idx_q + LINE_ONE;
                    line_base_d = line_base_q + BASE_STEP;
                end
            end
            default: ;
        endcase

        buff_wen_d  = vld_pipe_q[MEM_RD_LAT] ? sel_hot : 2'b00;
        buff_addr_d = vld_pipe_q[MEM_RD_LAT] ? col_pipe_q[MEM_RD_LAT] : buff_addr_q;
        buff_data_d = vld_pipe_q[MEM_RD_LAT] ? mem_data_i : buff_data_q;
        done_d      = (state_d == DONE) ? sel_hot : 2'b00;
        busy_d      = (state_d != IDLE);
    end

    // Stage k of the valid/column pipe lines up with read data k cycles after issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q       <= 1'b0;
            col_q       <= '0;
            line_idx_q  <= '0;
            line_base_q <= '0;
            fs_pend_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= '0;
            buff_wen_q  <= 2'b00;
            buff_addr_q <= '0;
            buff_data_q <= '0;
            done_q      <= 2'b00;
            busy_q      <= 1'b0;
            vld_pipe_q  <= '0;
            for (int k = 0; k <= MEM_RD_LAT; k++) begin
                col_pipe_q[k] <= '0;
            end
        end else begin
            sel_q       <= sel_d;
            col_q       <= col_d;
            line_idx_q  <= line_idx_d;
            line_base_q <= line_base_d;
            fs_pend_q   <= fs_pend_d;
            mem_ren_q   <= mem_ren_d;
            mem_addr_q  <= mem_addr_d;
            buff_wen_q  <= buff_wen_d;
            buff_addr_q <= buff_addr_d;
            buff_data_q <= buff_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            vld_pipe_q  <= {vld_pipe_q[MEM_RD_LAT-1:0], mem_ren_d};
            for (int k = MEM_RD_LAT; k > 0; k--) begin
                col_pipe_q[k] <= col_pipe_q[k-1];
            end
            col_pipe_q[0] <= col_d;
        end
    end

    assign mem_ren_o        = mem_ren_q;
    assign mem_addr_o       = mem_addr_q;
    assign buff_wen_o       = buff_wen_q;
    assign buff_addr_o      = buff_addr_q;
    assign buff_data_o      = buff_data_q;
    assign buff_fill_done_o = done_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_line_buff_fill.sv
// Directed self-checking bench for line_buff_fill: four instances with read
// latency 1..4 share stimulus, each fed by its own delayed frame-memory model.
module tb_line_buff_fill;

    localparam int N     = 160;
    localparam int LINES = 120;
    localparam int NINST = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic        frameStart;

    logic        memRen   [NINST];
    logic [14:0] memAddr  [NINST];
    logic [11:0] memData  [NINST];
    logic [1:0]  buffWen  [NINST];
    logic [7:0]  buffAddr [NINST];
    logic [11:0] buffData [NINST];
    logic [1:0]  fillDone [NINST];
    logic        busy     [NINST];

    logic        rdVld [NINST][NINST];
    logic [14:0] rdAdr [NINST][NINST];

    int cycleCnt = 0;
    int startCycle;
    int expBase;
    int expLine;
    int doneExp;
    logic [1:0] expHot;
    bit active;

    int rdCnt   [NINST];
    int wrCnt   [NINST];
    int rdErr   [NINST];
    int wrErr   [NINST];
    int busyErr [NINST];
    int doneCnt [NINST];

    int compareCount;
    int mismatchCount;

    for (genvar g = 0; g < NINST; g++) begin : gLat
        line_buff_fill #(.MEM_RD_LAT(g + 1)) uDut (
            .clk_i           (clk),
            .rst_i           (rst),
            .buff_fill_req_i (req),
            .frame_start_i   (frameStart),
            .mem_data_i      (memData[g]),
            .mem_ren_o       (memRen[g]),
            .mem_addr_o      (memAddr[g]),
            .buff_wen_o      (buffWen[g]),
            .buff_addr_o     (buffAddr[g]),
            .buff_data_o     (buffData[g]),
            .buff_fill_done_o(fillDone[g]),
            .busy_o          (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [11:0] dataOf(input int a);
        return 12'((a * 37) ^ (a >>> 5) ^ 12'h5A3);
    endfunction

    // Frame memory: instance i returns data (i+1) cycles after its read enable.
    always @(posedge clk) begin
        for (int i = 0; i < NINST; i++) begin
            for (int k = NINST - 1; k > 0; k--) begin
                rdVld[i][k] <= rdVld[i][k-1];
                rdAdr[i][k] <= rdAdr[i][k-1];
            end
            rdVld[i][0] <= memRen[i];
            rdAdr[i][0] <= memAddr[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NINST; i++) begin
            memData[i] = rdVld[i][i] ? dataOf(int'(rdAdr[i][i])) : 12'hBAD;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Per-cycle scoreboard: reads, writes and busy are tallied, done triggers the per-fill checks.
    always @(negedge clk) begin
        if (!rst && active) begin
            for (int i = 0; i < NINST; i++) begin
                int rel;
                int lat;
                rel = cycleCnt - startCycle;
                lat = i + 1;
                if (rel == 0) begin
                    rdCnt[i] = 0;
                    wrCnt[i] = 0;
                end
                if (busy[i] != ((rel >= 1) && (rel <= N + lat + 2))) busyErr[i]++;
                if (memRen[i]) begin
                    if ((int'(memAddr[i]) != expBase + rdCnt[i]) || (rel != rdCnt[i] + 1)) rdErr[i]++;
                    rdCnt[i]++;
                end
                if (buffWen[i] != 2'b00) begin
                    if ((buffWen[i] != expHot) || (int'(buffAddr[i]) != wrCnt[i]) ||
                        (buffData[i] != dataOf(expBase + wrCnt[i])) || (rel != wrCnt[i] + 2 + lat))
                        wrErr[i]++;
                    wrCnt[i]++;
                end
                if (fillDone[i] != 2'b00) begin
                    checkOutput($sformatf("doneBits/L%0d", lat), int'(fillDone[i]), int'(expHot));
                    checkOutput($sformatf("doneCycle/L%0d", lat), rel, N + lat + 2);
                    checkOutput($sformatf("readCount/L%0d", lat), rdCnt[i], N);
                    checkOutput($sformatf("writeCount/L%0d", lat), wrCnt[i], N);
                    doneCnt[i]++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] hot);
        @(posedge clk);
        #1;
        req        = r;
        startCycle = cycleCnt;
        expBase    = expLine * N;
        expHot     = hot;
        active     = 1'b1;
        @(posedge clk);
        #1;
        req = 2'b00;
    endtask

    task automatic finishFill(input bit framePending);
        repeat (168) @(posedge clk);
        #1;
        doneExp++;
        for (int i = 0; i < NINST; i++) begin
            checkOutput($sformatf("doneTotal/L%0d", i + 1), doneCnt[i], doneExp);
            checkOutput($sformatf("busyErrs/L%0d", i + 1), busyErr[i], 0);
            checkOutput($sformatf("readErrs/L%0d", i + 1), rdErr[i], 0);
            checkOutput($sformatf("writeErrs/L%0d", i + 1), wrErr[i], 0);
        end
        expLine = (framePending || expLine == LINES - 1) ? 0 : expLine + 1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "/ren"},  int'(memRen[0]),   0);
        checkOutput({tag, "/addr"}, int'(memAddr[0]),  0);
        checkOutput({tag, "/wen"},  int'(buffWen[0]),  0);
        checkOutput({tag, "/badr"}, int'(buffAddr[0]), 0);
        checkOutput({tag, "/bdat"}, int'(buffData[0]), 0);
        checkOutput({tag, "/done"}, int'(fillDone[0]), 0);
        for (int i = 0; i < NINST; i++) begin
            checkOutput($sformatf("%s/busy/L%0d", tag, i + 1), int'(busy[i]), 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        req = 2'b00;
        frameStart = 1'b0;
        active = 1'b0;
        compareCount = 0;
        mismatchCount = 0;
        expLine = 0;
        doneExp = 0;
        expHot = 2'b01;
        for (int i = 0; i < NINST; i++) begin
            rdCnt[i] = 0; wrCnt[i] = 0; rdErr[i] = 0;
            wrErr[i] = 0; busyErr[i] = 0; doneCnt[i] = 0;
        end
        #2 rst = 1'b1;
        #2 checkResetState("resetInit");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] first fill of A, then alternating fills through the frame wrap");
        applyStimulus(2'b01, 2'b01);
        checkOutput("cycle1Busy", int'(busy[0]), 1);
        checkOutput("cycle1Ren", int'(memRen[0]), 1);
        checkOutput("cycle1Addr", int'(memAddr[0]), 0);
        finishFill(1'b0);
        for (int k = 1; k <= LINES; k++) begin
            if (k % 2 == 1) applyStimulus(2'b10, 2'b10);
            else            applyStimulus(2'b01, 2'b01);
            finishFill(1'b0);
        end

        $display("[TB] request 11 serves A only");
        applyStimulus(2'b11, 2'b01);
        finishFill(1'b0);

        $display("[TB] request 10 while filling A is ignored");
        applyStimulus(2'b01, 2'b01);
        repeat (50) @(posedge clk);
        #1 req = 2'b10;
        @(posedge clk);
        #1 req = 2'b00;
        finishFill(1'b0);

        $display("[TB] frame start during fill of line 5");
        while (expLine != 5) begin
            applyStimulus(2'b10, 2'b10);
            finishFill(1'b0);
        end
        applyStimulus(2'b01, 2'b01);
        repeat (39) @(posedge clk);
        #1 frameStart = 1'b1;
        @(posedge clk);
        #1 frameStart = 1'b0;
        finishFill(1'b1);
        applyStimulus(2'b10, 2'b10);
        finishFill(1'b0);

        $display("[TB] frame start while idle");
        @(posedge clk);
        #1 frameStart = 1'b1;
        @(posedge clk);
        #1 frameStart = 1'b0;
        expLine = 0;
        applyStimulus(2'b01, 2'b01);
        finishFill(1'b0);

        $display("[TB] reset at column 80 aborts the fill");
        applyStimulus(2'b10, 2'b10);
        repeat (80) @(posedge clk);
        #3;
        active = 1'b0;
        rst = 1'b1;
        #1 checkResetState("resetAbort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (170) @(posedge clk);
        #1;
        for (int i = 0; i < NINST; i++) begin
            checkOutput($sformatf("abortNoDone/L%0d", i + 1), doneCnt[i], doneExp);
        end
        expLine = 0;
        applyStimulus(2'b01, 2'b01);
        finishFill(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
